// File: rtl/control_unit_pkg.sv
// rtl/control_unit_pkg.sv - shared types and encodings for the accumulator-datapath sequencer
//
// Package cu_pkg: sequencer state enum, op3 class constants, selData /
// selAddressAC encodings, condition-code constants, and the Moore decode
// of registered control strobes per state.
package cu_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH0 = 4'd1,
        S_DECODE = 4'd2,
        S_FETCH1 = 4'd3,
        S_FETCH2 = 4'd4,
        S_LDI_WR = 4'd5,
        S_LDA_EX = 4'd6,
        S_STA_RD = 4'd7,
        S_STA_WR = 4'd8,
        S_JMP_EX = 4'd9,
        S_ALU_A  = 4'd10,
        S_ALU_B  = 4'd11,
        S_ALU_WB = 4'd12
    } state_t;

    // Instruction classes (op3 = opcode[3:1]); 1xx is the ALU class
    localparam logic [2:0] OP_LDA = 3'b000;
    localparam logic [2:0] OP_STA = 3'b001;
    localparam logic [2:0] OP_JMP = 3'b010;
    localparam logic [2:0] OP_LDI = 3'b011;

    // Register-file write data source
    localparam logic [1:0] SD_MEM    = 2'b00;
    localparam logic [1:0] SD_RESULT = 2'b01;
    localparam logic [1:0] SD_DATA   = 2'b10;

    // Register-file address source
    localparam logic [1:0] SA_RD  = 2'b00;
    localparam logic [1:0] SA_RS1 = 2'b01;
    localparam logic [1:0] SA_RS2 = 2'b10;

    // Jump conditions
    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_Z      = 2'b01;
    localparam logic [1:0] COND_C      = 2'b10;
    localparam logic [1:0] COND_N      = 2'b11;

    // Control strobes that depend only on state (operation and the
    // JMP_EX pcEn/selPC are handled separately in the top).
    typedef struct packed {
        logic       pcEn;
        logic       selAddress;
        logic       mr;
        logic       mw;
        logic       LSEn;
        logic       RSEn;
        logic       DIEn;
        logic       enb;
        logic       dataRegEn;
        logic       resultRegEn;
        logic       CEn;
        logic       ZEn;
        logic       NEn;
        logic [1:0] selAddressAC;
        logic [1:0] selData;
        logic       busy;
        logic       instrDone;
    } ctrl_t;

    function automatic ctrl_t stateCtrl(state_t s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_FETCH0, S_FETCH1: begin
                c.mr   = 1'b1;
                c.LSEn = 1'b1;
                c.pcEn = 1'b1;
            end
            S_DECODE: c.DIEn = 1'b1;
            S_FETCH2: begin
                c.mr   = 1'b1;
                c.RSEn = 1'b1;
                c.pcEn = 1'b1;
            end
            S_LDI_WR: begin
                c.mr           = 1'b1;
                c.pcEn         = 1'b1;
                c.enb          = 1'b1;
                c.selData      = SD_MEM;
                c.selAddressAC = SA_RD;
                c.instrDone    = 1'b1;
            end
            S_LDA_EX: begin
                c.selAddress   = 1'b1;
                c.mr           = 1'b1;
                c.enb          = 1'b1;
                c.selData      = SD_MEM;
                c.selAddressAC = SA_RD;
                c.instrDone    = 1'b1;
            end
            S_STA_RD: begin
                c.selAddressAC = SA_RD;
                c.dataRegEn    = 1'b1;
            end
            S_STA_WR: begin
                c.selAddress = 1'b1;
                c.mw         = 1'b1;
                c.instrDone  = 1'b1;
            end
            S_JMP_EX: c.instrDone = 1'b1;
            S_ALU_A: begin
                c.selAddressAC = SA_RS1;
                c.dataRegEn    = 1'b1;
            end
            S_ALU_B: begin
                c.selAddressAC = SA_RS2;
                c.resultRegEn  = 1'b1;
                c.CEn          = 1'b1;
                c.ZEn          = 1'b1;
                c.NEn          = 1'b1;
            end
            S_ALU_WB: begin
                c.enb          = 1'b1;
                c.selData      = SD_RESULT;
                c.selAddressAC = SA_RD;
                c.instrDone    = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/control_unit_cond_eval.sv
// rtl/control_unit_cond_eval.sv - private C/Z/N flag copy and jump-condition mux
//
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   flagLoad     capture CC/ZZ/NN into the flags (asserted in ALU_B)
//   CC, ZZ, NN   ALU carry/zero/negative
//   cond         jump condition code (DI[2:1])
//   taken        condition holds against the registered flags
module cond_eval
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flagLoad,
    input  logic       CC,
    input  logic       ZZ,
    input  logic       NN,
    input  logic [1:0] cond,
    output logic       taken
);

    logic cFlag;
    logic zFlag;
    logic nFlag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cFlag <= 1'b0;
            zFlag <= 1'b0;
            nFlag <= 1'b0;
        end else if (flagLoad) begin
            cFlag <= CC;
            zFlag <= ZZ;
            nFlag <= NN;
        end
    end

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_ALWAYS: taken = 1'b1;
            COND_Z:      taken = zFlag;
            COND_C:      taken = cFlag;
            COND_N:      taken = nFlag;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator datapath
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   run                   enables fetch; sampled in IDLE and in each instruction's last state
//   toCU[3:0]             opcode nibble from memory; [3:1] latched in FETCH0, [0] is rd[1]
//   jmpCond[1:0]          DI[2:1]: jump condition / ALU function bit f0
//   CC, ZZ, NN            ALU flags
//   pcEn ... NEn          datapath enables and selects
//   selAddressAC[1:0]     register-file address source
//   selData[1:0]          register-file write data source
//   operation[2:0]        ALU function
//   busy                  high outside IDLE
//   instr_done            one-cycle pulse in the last cycle of each instruction
module control_unit
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic [3:0] toCU,
    input  logic [1:0] jmpCond,
    input  logic       CC,
    input  logic       ZZ,
    input  logic       NN,
    output logic       pcEn,
    output logic       selPC,
    output logic       selAddress,
    output logic       mr,
    output logic       mw,
    output logic       wordRegEn,
    output logic       LSEn,
    output logic       RSEn,
    output logic       DIEn,
    output logic       selALUsrc,
    output logic       enb,
    output logic       dataRegEn,
    output logic       resultRegEn,
    output logic       CEn,
    output logic       ZEn,
    output logic       NEn,
    output logic [1:0] selAddressAC,
    output logic [1:0] selData,
    output logic [2:0] operation,
    output logic       busy,
    output logic       instr_done
);

    state_t     state;
    logic [2:0] op3;
    ctrl_t      ctrl;
    logic [2:0] operationReg;
    logic       taken;
    logic       jmpTaken;
    logic       unusedRdHigh;

    // toCU[0] carries rd[1], which the datapath takes from DI directly
    assign unusedRdHigh = toCU[0];

    cond_eval uCondEval (
        .clk      (clk),
        .reset    (reset),
        .flagLoad (state == S_ALU_B),
        .CC       (CC),
        .ZZ       (ZZ),
        .NN       (NN),
        .cond     (jmpCond),
        .taken    (taken)
    );

    function automatic state_t nextOf(state_t s, logic [2:0] opClass, logic runIn);
        state_t n;
        n = s;
        case (s)
            S_IDLE:   n = runIn ? S_FETCH0 : S_IDLE;
            S_FETCH0: n = S_DECODE;
            S_DECODE: n = (opClass == OP_LDI) ? S_LDI_WR : S_FETCH1;
            S_FETCH1: n = opClass[2] ? S_ALU_A : S_FETCH2;
            S_FETCH2: begin
                case (opClass)
                    OP_LDA:  n = S_LDA_EX;
                    OP_STA:  n = S_STA_RD;
                    default: n = S_JMP_EX;
                endcase
            end
            S_STA_RD: n = S_STA_WR;
            S_ALU_A:  n = S_ALU_B;
            S_ALU_B:  n = S_ALU_WB;
            S_LDI_WR, S_LDA_EX, S_STA_WR, S_JMP_EX, S_ALU_WB:
                      n = runIn ? S_FETCH0 : S_IDLE;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

    // Outputs are registered alongside the state, decoded from the state
    // being entered, so they are glitch-free Moore outputs of that state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            op3          <= OP_LDA;
            ctrl         <= '0;
            operationReg <= 3'b000;
        end else begin
            state <= nextOf(state, op3, run);
            ctrl  <= stateCtrl(nextOf(state, op3, run));
            // DI (and so jmpCond) is stable from DECODE onward, so its
            // value in ALU_A is the one the ALU_B operation needs.
            operationReg <= (nextOf(state, op3, run) == S_ALU_B)
                            ? {op3[1:0], jmpCond[0]} : 3'b000;
            if (state == S_FETCH0) begin
                op3 <= toCU[3:1];
            end
        end
    end

    // The jump decision uses the registered flags and DI, which do not
    // change during JMP_EX, so this path is stable for the whole cycle.
    assign jmpTaken     = (state == S_JMP_EX) && taken;

    assign pcEn         = ctrl.pcEn | jmpTaken;
    assign selPC        = jmpTaken;
    assign selAddress   = ctrl.selAddress;
    assign mr           = ctrl.mr;
    assign mw           = ctrl.mw;
    assign wordRegEn    = 1'b0;
    assign LSEn         = ctrl.LSEn;
    assign RSEn         = ctrl.RSEn;
    assign DIEn         = ctrl.DIEn;
    assign selALUsrc    = 1'b0;
    assign enb          = ctrl.enb;
    assign dataRegEn    = ctrl.dataRegEn;
    assign resultRegEn  = ctrl.resultRegEn;
    assign CEn          = ctrl.CEn;
    assign ZEn          = ctrl.ZEn;
    assign NEn          = ctrl.NEn;
    assign selAddressAC = ctrl.selAddressAC;
    assign selData      = ctrl.selData;
    assign operation    = operationReg;
    assign busy         = ctrl.busy;
    assign instr_done   = ctrl.instrDone;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic [3:0] toCU;
    logic [1:0] jmpCond;
    logic       CC, ZZ, NN;

    logic pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn;
    logic selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn;
    logic [1:0] selAddressAC, selData;
    logic [2:0] operation;
    logic busy, instr_done;

    control_unit dut (
        .clk          (clk),
        .reset        (reset),
        .run          (run),
        .toCU         (toCU),
        .jmpCond      (jmpCond),
        .CC           (CC),
        .ZZ           (ZZ),
        .NN           (NN),
        .pcEn         (pcEn),
        .selPC        (selPC),
        .selAddress   (selAddress),
        .mr           (mr),
        .mw           (mw),
        .wordRegEn    (wordRegEn),
        .LSEn         (LSEn),
        .RSEn         (RSEn),
        .DIEn         (DIEn),
        .selALUsrc    (selALUsrc),
        .enb          (enb),
        .dataRegEn    (dataRegEn),
        .resultRegEn  (resultRegEn),
        .CEn          (CEn),
        .ZEn          (ZEn),
        .NEn          (NEn),
        .selAddressAC (selAddressAC),
        .selData      (selData),
        .operation    (operation),
        .busy         (busy),
        .instr_done   (instr_done)
    );

    always #5 clk = ~clk;

    logic [24:0] obs;
    assign obs = {pcEn, selPC, selAddress, mr, mw, wordRegEn, LSEn, RSEn, DIEn,
                  selALUsrc, enb, dataRegEn, resultRegEn, CEn, ZEn, NEn,
                  selAddressAC, selData, operation, busy, instr_done};

    localparam logic [24:0] DONE    = 25'h1 << 0;
    localparam logic [24:0] BUSY    = 25'h1 << 1;
    localparam logic [24:0] SD_RES  = 25'h1 << 5;
    localparam logic [24:0] SA_RS1  = 25'h1 << 7;
    localparam logic [24:0] SA_RS2  = 25'h1 << 8;
    localparam logic [24:0] NEN     = 25'h1 << 9;
    localparam logic [24:0] ZEN     = 25'h1 << 10;
    localparam logic [24:0] CEN     = 25'h1 << 11;
    localparam logic [24:0] RESREG  = 25'h1 << 12;
    localparam logic [24:0] DATAREG = 25'h1 << 13;
    localparam logic [24:0] ENB     = 25'h1 << 14;
    localparam logic [24:0] DIEN    = 25'h1 << 16;
    localparam logic [24:0] RSEN    = 25'h1 << 17;
    localparam logic [24:0] LSEN    = 25'h1 << 18;
    localparam logic [24:0] MW      = 25'h1 << 20;
    localparam logic [24:0] MR      = 25'h1 << 21;
    localparam logic [24:0] SELADDR = 25'h1 << 22;
    localparam logic [24:0] SELPC   = 25'h1 << 23;
    localparam logic [24:0] PCEN    = 25'h1 << 24;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference flags, updated at the instruction level
    logic fC = 1'b0, fZ = 1'b0, fN = 1'b0;

    function automatic logic [24:0] opField(input logic [2:0] op);
        return {20'b0, op, 2'b0};
    endfunction

    task automatic check(input logic [24:0] exp, input string tag);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idleCycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            toCU    = 4'($urandom);
            jmpCond = 2'($urandom);
            {CC, ZZ, NN} = 3'($urandom);
            run = (k == n - 1);
            #1 check(25'h0, tag);
            @(posedge clk); #1;
        end
    endtask

    // Runs one instruction from its first cycle. zForce >= 0 forces ZZ in
    // the flag-capture cycle of an ALU op; abortAt >= 0 asserts reset in
    // that cycle (0-based) and stops the instruction there.
    task automatic runInstr(input logic [7:0] b0, input logic contRun,
                            input int zForce, input int abortAt, input string tag);
        logic [2:0]  op3;
        logic [1:0]  cond;
        logic [2:0]  aluOp;
        logic        tk;
        logic [24:0] seq[$];
        op3   = b0[7:5];
        cond  = b0[2:1];
        aluOp = {b0[6:5], b0[1]};
        tk    = (cond == 2'd0) ? 1'b1 : (cond == 2'd1) ? fZ : (cond == 2'd2) ? fC : fN;

        seq.push_back(MR | LSEN | PCEN | BUSY);
        seq.push_back(DIEN | BUSY);
        if (op3 == 3'b011) begin
            seq.push_back(MR | PCEN | ENB | BUSY | DONE);
        end else begin
            seq.push_back(MR | LSEN | PCEN | BUSY);
            if (op3[2]) begin
                seq.push_back(SA_RS1 | DATAREG | BUSY);
                seq.push_back(SA_RS2 | opField(aluOp) | RESREG | CEN | ZEN | NEN | BUSY);
                seq.push_back(ENB | SD_RES | BUSY | DONE);
            end else begin
                seq.push_back(MR | RSEN | PCEN | BUSY);
                if (op3 == 3'b000) begin
                    seq.push_back(SELADDR | MR | ENB | BUSY | DONE);
                end else if (op3 == 3'b001) begin
                    seq.push_back(DATAREG | BUSY);
                    seq.push_back(SELADDR | MW | BUSY | DONE);
                end else begin
                    seq.push_back((tk ? (PCEN | SELPC) : 25'h0) | BUSY | DONE);
                end
            end
        end

        for (int i = 0; i < seq.size(); i++) begin
            toCU    = (i == 0) ? b0[7:4] : 4'($urandom);
            jmpCond = (i >= 2) ? b0[2:1] : 2'($urandom);
            {CC, ZZ, NN} = 3'($urandom);
            if (op3[2] && i == 4 && zForce >= 0) ZZ = zForce[0];
            run = (i == seq.size() - 1) ? contRun : 1'($urandom);
            if (i == abortAt) begin
                {CC, ZZ, NN} = 3'b111;
                #1 reset = 1'b1;
                #1 check(25'h0, {tag, "_reset_now"});
                @(posedge clk); #1;
                check(25'h0, {tag, "_reset_edge"});
                reset = 1'b0;
                run   = 1'b0;
                fC = 1'b0; fZ = 1'b0; fN = 1'b0;
                break;
            end
            #1 check(seq[i], $sformatf("%s_c%0d", tag, i + 1));
            if (op3[2] && i == 4) begin
                fC = CC; fZ = ZZ; fN = NN;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       cont;
        reset = 1'b1; run = 1'b0; toCU = 4'h0; jmpCond = 2'b00;
        CC = 1'b0; ZZ = 1'b0; NN = 1'b0;
        repeat (2) @(posedge clk);
        #1 check(25'h0, "reset_state");
        reset = 1'b0;

        idleCycles(5, "idle_run0");
        runInstr(8'h78, 1'b1, -1, -1, "ldi78");
        runInstr(8'hA2, 1'b1,  1, -1, "alu_a2_z1");
        runInstr(8'h42, 1'b1, -1, -1, "jmp_z_taken");
        runInstr(8'h30, 1'b1, -1, -1, "sta30");
        runInstr(8'hA2, 1'b1,  0, -1, "alu_a2_z0");
        runInstr(8'h42, 1'b0, -1, -1, "jmp_z_not");
        idleCycles(2, "idle_after_jmp");
        runInstr(8'h10, 1'b0, -1, -1, "lda_rundrop");
        idleCycles(3, "idle_after_lda");
        runInstr(8'hA2, 1'b1,  1, -1, "alu_set_z");
        runInstr(8'hA2, 1'b1,  1,  4, "alu_abort");
        idleCycles(2, "idle_after_abort");
        runInstr(8'h42, 1'b1, -1, -1, "jmp_after_abort");

        for (int n = 0; n < 250; n++) begin
            b    = 8'($urandom);
            cont = ($urandom_range(0, 7) != 0);
            runInstr(b, cont, -1, -1, $sformatf("rnd%0d_%02h", n, b));
            if (!cont) idleCycles($urandom_range(1, 3), "rnd_idle");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
